// File: rtl/bsg_reduce_stream.sv
// bsg_reduce_stream: folds a per-word AND/OR/XOR reduction across a multi-beat packet.
// Define BSG_REDUCE_STREAM_COUNT_EN to export the folded-word count on count_o.

module bsg_reduce_stream_word #(
    parameter int width_p  = 1,
    parameter int xor_p    = 0,
    parameter int and_p    = 0,
    parameter int or_p     = 0,
    parameter int harden_p = 0
) (
    input  logic [width_p-1:0] i_data,
    output logic               o_bit
);
    logic w_bit;

    always_comb begin
        if (and_p != 0)     w_bit = &i_data;
        else if (or_p != 0) w_bit = |i_data;
        else                w_bit = ^i_data;
    end

    if (harden_p != 0) begin : g_hard
        // No hardened reduction cells exist in this library; both variants use the soft tree.
        assign o_bit = w_bit;
    end else begin : g_soft
        assign o_bit = w_bit;
    end
endmodule

module bsg_reduce_stream #(
    parameter int width_p     = -1,
    parameter int xor_p       = 0,
    parameter int and_p       = 0,
    parameter int or_p        = 0,
    parameter int max_words_p = 16,
    parameter int harden_p    = 0,
    localparam int cnt_w_lp   = $clog2(max_words_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic                v_o,
    output logic                data_o,
    output logic [cnt_w_lp-1:0] count_o,
    output logic                truncated_o,
    input  logic                yumi_i
);
    if ((int'(xor_p != 0) + int'(and_p != 0) + int'(or_p != 0)) != 1
        || width_p < 1 || max_words_p < 1) begin : g_param_err
        $error("bsg_reduce_stream: need exactly one of xor_p/and_p/or_p, width_p>=1, max_words_p>=1");
    end

    typedef enum logic [0:0] {S_ACCUM = 1'b0, S_DONE = 1'b1} state_e;

    localparam logic identity_lp = (and_p != 0);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_acc;
    logic   r_trunc;
    logic   w_word_bit;
    logic   w_acc_nxt;
    logic   w_accept;
    logic   w_at_limit;
    logic   w_end_pkt;
    logic   w_release;

    bsg_reduce_stream_word #(
        .width_p  (width_p),
        .xor_p    (xor_p),
        .and_p    (and_p),
        .or_p     (or_p),
        .harden_p (harden_p)
    ) u_word (
        .i_data (data_i),
        .o_bit  (w_word_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_ACCUM;
        else         r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        v_o         = 1'b0;
        case (r_state)
            S_ACCUM: begin
                ready_o = 1'b1;
                if (v_i && (last_i || w_at_limit)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                v_o = 1'b1;
                if (yumi_i) w_state_nxt = S_ACCUM;
            end
        endcase
    end

    assign w_accept  = v_i & ready_o;
    assign w_end_pkt = w_accept & (last_i | w_at_limit);
    assign w_release = v_o & yumi_i;

    always_comb begin
        if (and_p != 0)     w_acc_nxt = r_acc & w_word_bit;
        else if (or_p != 0) w_acc_nxt = r_acc | w_word_bit;
        else                w_acc_nxt = r_acc ^ w_word_bit;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || w_release) begin
            r_acc   <= identity_lp;
            r_trunc <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            if (w_end_pkt) r_trunc <= ~last_i;
        end
    end

`ifdef BSG_REDUCE_STREAM_COUNT_EN
    logic [cnt_w_lp-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i || w_release) r_count <= '0;
        else if (w_accept)        r_count <= r_count + 1'b1;
    end

    assign w_at_limit = (r_count == cnt_w_lp'(max_words_p - 1));
    assign count_o    = r_count;
`else
    // Words still allowed before the forced stop; zero means the next accept ends the packet.
    logic [cnt_w_lp-1:0] r_left;

    always_ff @(posedge clk_i) begin
        if (reset_i || w_release) r_left <= cnt_w_lp'(max_words_p - 1);
        else if (w_accept)        r_left <= r_left - 1'b1;
    end

    assign w_at_limit = (r_left == '0);
    assign count_o    = '0;
`endif

    assign data_o      = r_acc;
    assign truncated_o = r_trunc;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_reduce_stream: yumi_i asserted while v_o=0");
        end
    end
endmodule

// File: tb/tb_bsg_reduce_stream.sv
// Randomized bench for bsg_reduce_stream: four instances (AND/XOR/OR/single-word) against a packet-level model.
// Expectations follow BSG_REDUCE_STREAM_COUNT_EN in the same way the design does.

module tb_bsg_reduce_stream;
    localparam int NI = 4;

`ifdef BSG_REDUCE_STREAM_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       v_i     [NI];
    logic [7:0] data_i  [NI];
    logic       last_i  [NI];
    logic       yumi_i  [NI];
    logic       ready_o [NI];
    logic       v_o     [NI];
    logic       data_o  [NI];
    logic       trunc_o [NI];
    logic [4:0] cnt     [NI];
    logic [4:0] cnt_and;
    logic [4:0] cnt_xor;
    logic [2:0] cnt_or;
    logic [0:0] cnt_one;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pkt_q[$];
    bit         e_bit;
    int         e_cnt;
    bit         e_tr;

    always #5 clk = ~clk;

    assign cnt[0] = cnt_and;
    assign cnt[1] = cnt_xor;
    assign cnt[2] = {2'b00, cnt_or};
    assign cnt[3] = {4'b0000, cnt_one};

    bsg_reduce_stream #(.width_p(8), .and_p(1), .max_words_p(16)) u_and (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i[0]), .data_i(data_i[0]), .last_i(last_i[0]),
        .ready_o(ready_o[0]), .v_o(v_o[0]), .data_o(data_o[0]), .count_o(cnt_and),
        .truncated_o(trunc_o[0]), .yumi_i(yumi_i[0]));

    bsg_reduce_stream #(.width_p(8), .xor_p(1), .max_words_p(16)) u_xor (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i[1]), .data_i(data_i[1]), .last_i(last_i[1]),
        .ready_o(ready_o[1]), .v_o(v_o[1]), .data_o(data_o[1]), .count_o(cnt_xor),
        .truncated_o(trunc_o[1]), .yumi_i(yumi_i[1]));

    bsg_reduce_stream #(.width_p(8), .or_p(1), .max_words_p(4)) u_or (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i[2]), .data_i(data_i[2]), .last_i(last_i[2]),
        .ready_o(ready_o[2]), .v_o(v_o[2]), .data_o(data_o[2]), .count_o(cnt_or),
        .truncated_o(trunc_o[2]), .yumi_i(yumi_i[2]));

    bsg_reduce_stream #(.width_p(8), .xor_p(1), .max_words_p(1)) u_one (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i[3]), .data_i(data_i[3]), .last_i(last_i[3]),
        .ready_o(ready_o[3]), .v_o(v_o[3]), .data_o(data_o[3]), .count_o(cnt_one),
        .truncated_o(trunc_o[3]), .yumi_i(yumi_i[3]));

    // 0 = AND, 1 = XOR, 2 = OR
    function automatic int op_of(input int d);
        case (d)
            0:       return 0;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int max_of(input int d);
        case (d)
            2:       return 4;
            3:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int d);
        check($sformatf("idle_v[%0d]", d), 32'(v_o[d]), 0);
        check($sformatf("idle_ready[%0d]", d), 32'(ready_o[d]), 1);
        check($sformatf("idle_data[%0d]", d), 32'(data_o[d]), 32'(op_of(d) == 0));
        check($sformatf("idle_cnt[%0d]", d), 32'(cnt[d]), 0);
        check($sformatf("idle_trunc[%0d]", d), 32'(trunc_o[d]), 0);
    endtask

    task automatic check_result(input int d);
        check($sformatf("v_o[%0d]", d), 32'(v_o[d]), 1);
        check($sformatf("ready_done[%0d]", d), 32'(ready_o[d]), 0);
        check($sformatf("data_o[%0d]", d), 32'(data_o[d]), 32'(e_bit));
        check($sformatf("count_o[%0d]", d), 32'(cnt[d]), 32'(e_cnt));
        check($sformatf("trunc_o[%0d]", d), 32'(trunc_o[d]), 32'(e_tr));
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic drive_word(input int d, input logic [7:0] w, input logic l);
        int budget = 0;
        v_i[d] = 1'b1; data_i[d] = w; last_i[d] = l;
        while (!ready_o[d] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("ready_wait[%0d]", d), 32'(ready_o[d]), 1);
        @(negedge clk);
        v_i[d] = 1'b0; data_i[d] = 8'($urandom); last_i[d] = 1'($urandom);
    endtask

    // Drives pkt_q as one packet and sets the model's expected result.
    task automatic feed(input int d, input bit with_last);
        e_bit = (op_of(d) == 0);
        foreach (pkt_q[i]) begin
            case (op_of(d))
                0:       e_bit = e_bit & (pkt_q[i] == 8'hFF);
                1:       e_bit = e_bit ^ (^pkt_q[i]);
                default: e_bit = e_bit | (pkt_q[i] != 8'h00);
            endcase
        end
        e_cnt = COUNT_EN ? pkt_q.size() : 0;
        e_tr  = !with_last;
        foreach (pkt_q[i]) begin
            check($sformatf("busy_v[%0d]", d), 32'(v_o[d]), 0);
            drive_word(d, pkt_q[i], with_last && (i == pkt_q.size() - 1));
        end
    endtask

    task automatic expect_done(input int d, input int hold);
        for (int k = 0; k <= hold; k++) begin
            check_result(d);
            if (k < hold) @(negedge clk);
        end
    endtask

    task automatic pop(input int d);
        yumi_i[d] = 1'b1;
        @(negedge clk);
        yumi_i[d] = 1'b0;
        check_idle(d);
    endtask

    task automatic do_packet(input int d, input bit with_last, input int hold);
        feed(d, with_last);
        expect_done(d, hold);
        pop(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < NI; d++) begin
            v_i[d] = 1'b0; data_i[d] = 8'h00; last_i[d] = 1'b0; yumi_i[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        for (int d = 0; d < NI; d++) check_idle(d);

        pkt_q = '{8'hFF, 8'hFF, 8'hFF};        do_packet(0, 1'b1, 0);
        pkt_q = '{8'hFF, 8'h7F};               do_packet(0, 1'b1, 0);
        pkt_q = '{8'h01, 8'h03, 8'h07};        do_packet(1, 1'b1, 5);
        pkt_q = '{8'h00, 8'h00, 8'h00, 8'h00}; do_packet(2, 1'b0, 1);
        pkt_q = '{8'h00, 8'h10};               do_packet(2, 1'b1, 0);
        pkt_q = '{8'h03};                      do_packet(3, 1'b1, 0);
        pkt_q = '{8'h01};                      do_packet(3, 1'b0, 0);

        // Held word during DONE must wait for the release and then open the next packet.
        pkt_q = '{8'hFF};
        feed(0, 1'b1);
        v_i[0] = 1'b1; data_i[0] = 8'h00; last_i[0] = 1'b1;
        expect_done(0, 3);
        yumi_i[0] = 1'b1;
        @(negedge clk);
        yumi_i[0] = 1'b0;
        check("bp_ready", 32'(ready_o[0]), 1);
        check("bp_v", 32'(v_o[0]), 0);
        @(negedge clk);
        v_i[0] = 1'b0;
        e_bit = 1'b0; e_cnt = COUNT_EN ? 1 : 0; e_tr = 1'b0;
        check_result(0);
        pop(0);

        // Reset mid-packet drops the partial AND, which would otherwise have been 0.
        drive_word(0, 8'hFF, 1'b0);
        drive_word(0, 8'h00, 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_idle(0);
        pkt_q = '{8'hFF};                      do_packet(0, 1'b1, 0);

        // Reset while DONE discards the held result.
        pkt_q = '{8'h01};
        feed(1, 1'b1);
        check("held_v", 32'(v_o[1]), 1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_idle(1);

        for (int p = 0; p < 60; p++) begin
            int  d;
            int  n;
            bit  wl;
            d = int'($urandom_range(0, NI - 1));
            n = int'($urandom_range(1, max_of(d)));
            wl = (n < max_of(d)) ? 1'b1 : 1'($urandom);
            pkt_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       pkt_q.push_back(8'h00);
                    1:       pkt_q.push_back(8'hFF);
                    default: pkt_q.push_back(8'($urandom));
                endcase
            end
            do_packet(d, wl, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
